// File: rtl/sonar_medidor_pkg.sv
// Shared types for the sonar range stage: FSM state codes, BCD digit type and
// the saturating three-digit BCD increment used by the distance counter.
package sonar_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    ENVIA_TRIGGER = 4'd1,
    ESPERA_ECHO   = 4'd2,
    MEDINDO       = 4'd3,
    ARMAZENA      = 4'd4,
    FINAL_MEDIDA  = 4'd5,
    ERRO          = 4'd6
  } estado_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [11:0] BCD_MAX = 12'h999;

  // Returns v+1 in BCD, holding at 999 instead of wrapping to 000.
  function automatic logic [11:0] bcd_incr_sat(input logic [11:0] v);
    bcd_digit_t c;
    bcd_digit_t d;
    bcd_digit_t u;
    logic [11:0] r;
    {c, d, u} = v;
    if (v == BCD_MAX) begin
      r = v;
    end else begin
      if (u == 4'd9) begin
        u = 4'd0;
        if (d == 4'd9) begin
          d = 4'd0;
          c = c + 4'd1;
        end else begin
          d = d + 4'd1;
        end
      end else begin
        u = u + 4'd1;
      end
      r = {c, d, u};
    end
    return r;
  endfunction

endpackage

// File: rtl/sonar_medidor_if.sv
// Sensor-side and result-side signals of the sonar range stage.
// master drives the request and echo; slave is the measuring block.
interface sonar_medidor_if;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        timeout;
  logic [3:0]  db_estado;

  modport master (
    output medir, echo,
    input  trigger, medida, pronto, timeout, db_estado
  );

  modport slave (
    input  medir, echo,
    output trigger, medida, pronto, timeout, db_estado
  );
endinterface

// File: rtl/sonar_medidor_contador_bcd_3digitos.sv
// Three-digit BCD counter with clear, increment enable and hold at 999.
// proximo exposes the saturated next value so callers can round without a second adder.
module contador_bcd_3digitos
  import sonar_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        limpa,
  input  logic        conta,
  output logic [11:0] valor,
  output logic [11:0] proximo,
  output logic        no_maximo
);

  assign proximo   = bcd_incr_sat(valor);
  assign no_maximo = (valor == BCD_MAX);

  always_ff @(posedge clock) begin
    if (!reset || limpa) begin
      valor <= 12'h000;
    end else if (conta) begin
      valor <= proximo;
    end
  end

endmodule

// File: rtl/sonar_medidor.sv
// HC-SR04 range measurement: trigger pulse, echo timing and BCD centimetre result.
// Echo is resynchronised; result lands two edges after the synced echo fall.
module sonar_medidor
  import sonar_pkg::*;
#(
  parameter int CLOCKS_PER_CM  = 2941,
  parameter int TRIGGER_CYCLES = 500,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic            clock,
  input  logic            reset,
  sonar_medidor_if.slave  bus
);

  localparam int SUB_W = $clog2(CLOCKS_PER_CM);
  localparam int TRG_W = $clog2(TRIGGER_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SUB_W-1:0] SUB_ULT  = SUB_W'(CLOCKS_PER_CM - 1);
  localparam logic [SUB_W-1:0] SUB_MEIO = SUB_W'(CLOCKS_PER_CM / 2);
  localparam logic [TRG_W-1:0] TRG_ULT  = TRG_W'(TRIGGER_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ULT  = TMO_W'(TIMEOUT_CYCLES - 1);

  estado_t          estado;
  logic [TRG_W-1:0] trg_cnt;
  logic [SUB_W-1:0] sub_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             echo_s1, echo_s2, echo_s3;
  logic             sobe, desce, tmo_fim, em_espera;
  logic             trigger_r, pronto_r, timeout_r;
  logic [11:0]      medida_r;
  logic [11:0]      bcd_valor, bcd_prox;
  logic             bcd_max, bcd_conta;

  always_ff @(posedge clock) begin
    if (!reset) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_s3 <= 1'b0;
    end else begin
      echo_s1 <= bus.echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  // Edges are relative to the previous synced sample, so an echo that is
  // already high on entry to ESPERA_ECHO never looks like a rising edge.
  assign sobe      = echo_s2 & ~echo_s3;
  assign desce     = ~echo_s2 & echo_s3;
  assign em_espera = (estado == ESPERA_ECHO) || (estado == MEDINDO);
  assign tmo_fim   = em_espera && (tmo_cnt == TMO_ULT);

  always_ff @(posedge clock) begin
    if (!reset || estado == ENVIA_TRIGGER) begin
      tmo_cnt <= '0;
    end else if (em_espera) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || estado == ENVIA_TRIGGER) begin
      sub_cnt <= '0;
    end else if (estado == MEDINDO) begin
      sub_cnt <= (sub_cnt == SUB_ULT) ? '0 : sub_cnt + SUB_W'(1);
    end
  end

  assign bcd_conta = (estado == MEDINDO) && (sub_cnt == SUB_ULT) && !bcd_max;

  contador_bcd_3digitos u_bcd (
    .clock     (clock),
    .reset     (reset),
    .limpa     (estado == ENVIA_TRIGGER),
    .conta     (bcd_conta),
    .valor     (bcd_valor),
    .proximo   (bcd_prox),
    .no_maximo (bcd_max)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado    <= INICIAL;
      trg_cnt   <= '0;
      trigger_r <= 1'b0;
      pronto_r  <= 1'b0;
      timeout_r <= 1'b0;
      medida_r  <= 12'h000;
    end else begin
      pronto_r  <= 1'b0;
      timeout_r <= 1'b0;
      case (estado)
        INICIAL: begin
          if (bus.medir) begin
            estado    <= ENVIA_TRIGGER;
            trigger_r <= 1'b1;
            trg_cnt   <= '0;
          end
        end
        ENVIA_TRIGGER: begin
          if (trg_cnt == TRG_ULT) begin
            estado    <= ESPERA_ECHO;
            trigger_r <= 1'b0;
          end else begin
            trg_cnt <= trg_cnt + TRG_W'(1);
          end
        end
        ESPERA_ECHO: begin
          if (tmo_fim) begin
            estado    <= ERRO;
            timeout_r <= 1'b1;
          end else if (sobe) begin
            estado <= MEDINDO;
          end
        end
        MEDINDO: begin
          // Timeout is checked first so it wins over a coincident echo fall.
          if (tmo_fim) begin
            estado    <= ERRO;
            timeout_r <= 1'b1;
          end else if (desce) begin
            estado <= ARMAZENA;
          end
        end
        ARMAZENA: begin
          medida_r <= (sub_cnt >= SUB_MEIO) ? bcd_prox : bcd_valor;
          pronto_r <= 1'b1;
          estado   <= FINAL_MEDIDA;
        end
        FINAL_MEDIDA, ERRO: estado <= INICIAL;
        default:            estado <= INICIAL;
      endcase
    end
  end

  assign bus.trigger   = trigger_r;
  assign bus.pronto    = pronto_r;
  assign bus.timeout   = timeout_r;
  assign bus.medida    = medida_r;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_sonar_medidor.sv
// Bench for sonar_medidor: directed and random echo widths against an arithmetic
// distance model, plus reset, timeout, stray-request and pre-high-echo cases.
module tb_sonar_medidor;
  import sonar_pkg::*;

  localparam int CPM = 10;
  localparam int TRG = 5;
  localparam int TMO = 20000;

  logic clock = 1'b0;
  logic reset = 1'b0;

  sonar_medidor_if bus ();

  sonar_medidor #(
    .CLOCKS_PER_CM  (CPM),
    .TRIGGER_CYCLES (TRG),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  int          prontos = 0, timeouts = 0, sobrepostos = 0;
  int          prontos_esp = 0, timeouts_esp = 0;
  logic [11:0] medida_ref = 12'h000;

  always @(negedge clock) begin
    if (bus.pronto) prontos++;
    if (bus.timeout) timeouts++;
    if (bus.pronto && bus.timeout) sobrepostos++;
  end

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_vec++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic passo(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Distance in whole cm, rounded half up, capped at 999, then split into BCD digits.
  function automatic logic [11:0] ref_bcd(input int w);
    int n;
    n = w / CPM;
    if ((w % CPM) >= CPM / 2) n++;
    if (n > 999) n = 999;
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // w = 0 means the echo never rises and a timeout is expected.
  task automatic medicao(input string tag, input int w, input int atraso,
                         input bit medir_meio, input bit eco_previo);
    int cnt;
    if (eco_previo) begin
      bus.echo = 1'b1;
      passo(5);
    end
    bus.medir = 1'b1;
    passo(1);
    bus.medir = 1'b0;
    cnt = 0;
    while (bus.trigger && cnt < 100) begin
      cnt++;
      passo(1);
    end
    confere({tag, "/trigger_len"}, cnt, TRG);
    if (eco_previo) begin
      passo(50);
      confere({tag, "/still_waiting"}, bus.db_estado, 2);
      bus.echo = 1'b0;
      passo(5);
    end
    passo(atraso);
    if (w > 0) begin
      bus.echo = 1'b1;
      if (medir_meio) begin
        passo(w / 2);
        bus.medir = 1'b1;
        passo(1);
        bus.medir = 1'b0;
        passo(w - w / 2 - 1);
      end else begin
        passo(w);
      end
      bus.echo = 1'b0;
    end
    cnt = (w > 0) ? 0 : atraso;
    while (!bus.pronto && !bus.timeout && cnt < TMO + 100) begin
      passo(1);
      cnt++;
    end
    if (w == 0) begin
      timeouts_esp++;
      confere({tag, "/timeout"}, bus.timeout, 1);
      confere({tag, "/pronto"}, bus.pronto, 0);
      confere({tag, "/timeout_latency"}, cnt, TMO);
    end else begin
      prontos_esp++;
      medida_ref = ref_bcd(w);
      confere({tag, "/pronto"}, bus.pronto, 1);
      confere({tag, "/timeout"}, bus.timeout, 0);
      confere({tag, "/pronto_latency"}, cnt, 4);
    end
    confere({tag, "/medida"}, bus.medida, medida_ref);
    passo(1);
    confere({tag, "/single_pulse"}, {bus.pronto, bus.timeout}, 0);
    passo(5);
    confere({tag, "/idle_after"}, bus.db_estado, 0);
  endtask

  initial begin
    int w;
    bus.medir = 1'b0;
    bus.echo  = 1'b0;
    reset     = 1'b0;
    passo(3);
    confere("reset/trigger", bus.trigger, 0);
    confere("reset/pronto", bus.pronto, 0);
    confere("reset/timeout", bus.timeout, 0);
    confere("reset/medida", bus.medida, 12'h000);
    confere("reset/db_estado", bus.db_estado, 0);
    reset = 1'b1;
    passo(2);
    confere("idle/db_estado", bus.db_estado, 0);

    medicao("round_up", 205, 3, 1'b0, 1'b0);
    medicao("round_down", 204, 7, 1'b0, 1'b0);
    medicao("carry_099", 990, 2, 1'b0, 1'b0);
    medicao("carry_100", 995, 2, 1'b0, 1'b0);
    medicao("saturate", 12000, 1, 1'b0, 1'b0);
    medicao("timeout", 0, 0, 1'b0, 1'b0);
    medicao("medir_during", 333, 4, 1'b1, 1'b0);
    medicao("pre_high_echo", 157, 2, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      w = int'($urandom_range(2, 1500));
      medicao("random", w, int'($urandom_range(0, 20)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a measurement.
    bus.medir = 1'b1;
    passo(1);
    bus.medir = 1'b0;
    passo(TRG + 2);
    bus.echo = 1'b1;
    passo(30);
    confere("mid_reset/in_medindo", bus.db_estado, 3);
    reset = 1'b0;
    passo(1);
    confere("mid_reset/db_estado", bus.db_estado, 0);
    confere("mid_reset/trigger", bus.trigger, 0);
    confere("mid_reset/pronto", bus.pronto, 0);
    confere("mid_reset/timeout", bus.timeout, 0);
    confere("mid_reset/medida", bus.medida, 12'h000);
    reset    = 1'b1;
    bus.echo = 1'b0;
    medida_ref = 12'h000;
    passo(3);

    // medir held high restarts right after the measurement completes.
    bus.medir = 1'b1;
    passo(TRG + 3);
    bus.echo = 1'b1;
    passo(50);
    bus.echo = 1'b0;
    w = 0;
    while (!bus.pronto && w < 100) begin
      passo(1);
      w++;
    end
    prontos_esp++;
    confere("back2back/medida", bus.medida, ref_bcd(50));
    passo(1);
    confere("back2back/inicial", bus.db_estado, 0);
    passo(1);
    confere("back2back/restart", bus.db_estado, 1);
    bus.medir = 1'b0;
    reset = 1'b0;
    passo(1);
    reset = 1'b1;
    passo(3);

    confere("total/pronto_pulses", prontos, prontos_esp);
    confere("total/timeout_pulses", timeouts, timeouts_esp);
    confere("total/overlap", sobrepostos, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
